// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, BTB-predicted next PC, registered fetch/decode outputs.
// Latency: o_valid rises the cycle after i_imem_valid; decode stall parks a response in a hold register.
module fetch_stage #(
    parameter int                      ADDR_WIDTH  = 64,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_stall_dec,
    input  logic                    i_redirect,
    input  logic [ADDR_WIDTH-1:0]   i_redirect_pc,
    output logic                    o_imem_req,
    output logic [ADDR_WIDTH-1:0]   o_imem_addr,
    input  logic                    i_imem_ack,
    input  logic                    i_imem_valid,
    input  logic [INSTR_WIDTH-1:0]  i_imem_data,
    input  logic                    i_btb_hit_taken,
    input  logic [ADDR_WIDTH-1:0]   i_btb_target,
    input  logic [1:0]              i_btb_way,
    output logic [INSTR_WIDTH-1:0]  o_instruction,
    output logic [ADDR_WIDTH-1:0]   o_pc,
    output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]   o_pc_target_pred,
    output logic [1:0]              o_btb_way,
    output logic                    o_branch_pred_taken,
    output logic                    o_valid
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_plus4;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] next_pc;
        logic [1:0]            way;
        logic                  taken;
    } req_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic [ADDR_WIDTH-1:0]  pc_plus4;
        logic [ADDR_WIDTH-1:0]  target;
        logic [1:0]             way;
        logic                   taken;
        logic                   valid;
    } fd_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   kill_q, kill_d;
    req_t                   req_q, req_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    fd_t                    fd_q, fd_d;
    fd_t                    fd_bubble;
    logic                   deliver;
    logic [INSTR_WIDTH-1:0] deliver_instr;
    logic [ADDR_WIDTH-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    always_comb begin
        fd_bubble       = '0;
        fd_bubble.instr = NOP_INSTR;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        req_d         = req_q;
        hold_d        = hold_q;
        deliver       = 1'b0;
        deliver_instr = hold_q;

        case (state_q)
            S_REQ: begin
                if (i_imem_ack) begin
                    req_d.pc       = pc_q;
                    req_d.pc_plus4 = pc_plus4;
                    req_d.target   = i_btb_target;
                    req_d.way      = i_btb_way;
                    req_d.taken    = i_btb_hit_taken;
                    req_d.next_pc  = i_btb_hit_taken ? i_btb_target : pc_plus4;
                    // A redirect racing the ack leaves this request stale.
                    kill_d         = i_redirect;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_valid) begin
                    state_d = S_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else if (!i_redirect) begin
                        if (!i_stall_dec) begin
                            deliver       = 1'b1;
                            deliver_instr = i_imem_data;
                            pc_d          = req_q.next_pc;
                        end else begin
                            hold_d  = i_imem_data;
                            state_d = S_HOLD;
                        end
                    end
                end else if (i_redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_redirect) begin
                    state_d = S_REQ;
                end else if (!i_stall_dec) begin
                    deliver = 1'b1;
                    pc_d    = req_q.next_pc;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (i_redirect) begin
            pc_d = i_redirect_pc;
        end
    end

    always_comb begin
        fd_d = fd_q;
        if (i_redirect) begin
            fd_d = fd_bubble;
        end else if (deliver) begin
            fd_d.instr    = deliver_instr;
            fd_d.pc       = req_q.pc;
            fd_d.pc_plus4 = req_q.pc_plus4;
            fd_d.target   = req_q.target;
            fd_d.way      = req_q.way;
            fd_d.taken    = req_q.taken;
            fd_d.valid    = 1'b1;
        end else if (!i_stall_dec) begin
            fd_d = fd_bubble;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            req_q   <= '0;
            hold_q  <= NOP_INSTR;
            fd_q    <= fd_bubble;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            hold_q  <= hold_d;
            fd_q    <= fd_d;
        end
    end

    // Request is masked while reset is held so nothing is issued in the reset cycle.
    assign o_imem_req          = (state_q == S_REQ) && i_arst;
    assign o_imem_addr         = pc_q;
    assign o_instruction       = fd_q.instr;
    assign o_pc                = fd_q.pc;
    assign o_pc_plus4          = fd_q.pc_plus4;
    assign o_pc_target_pred    = fd_q.target;
    assign o_btb_way           = fd_q.way;
    assign o_branch_pred_taken = fd_q.taken;
    assign o_valid             = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic against a transaction model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_arst = 1'b0, i_stall_dec = 1'b0, i_redirect = 1'b0;
    logic [63:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_ack = 1'b0, i_imem_valid = 1'b0;
    logic [31:0] i_imem_data = '0;
    logic        i_btb_hit_taken = 1'b0;
    logic [63:0] i_btb_target = '0;
    logic [1:0]  i_btb_way = '0;
    logic [31:0] o_instruction;
    logic [63:0] o_pc, o_pc_plus4, o_pc_target_pred;
    logic [1:0]  o_btb_way;
    logic        o_branch_pred_taken, o_valid;

    fetch_stage dut (
        .i_clk(clk), .i_arst(i_arst), .i_stall_dec(i_stall_dec),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_valid(i_imem_valid), .i_imem_data(i_imem_data),
        .i_btb_hit_taken(i_btb_hit_taken), .i_btb_target(i_btb_target), .i_btb_way(i_btb_way),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
        .o_pc_target_pred(o_pc_target_pred), .o_btb_way(o_btb_way),
        .o_branch_pred_taken(o_branch_pred_taken), .o_valid(o_valid)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc, pc4, tgt;
        logic [1:0]  way;
        bit          tk, v;
    } fd_t;

    typedef struct {
        logic [63:0] pc, tgt;
        logic [1:0]  way;
        bit          tk;
    } rq_t;

    // Transaction-level model: fetch address, the one outstanding request, a parked response, decode view.
    logic [63:0] m_pc = '0;
    bit          m_busy = 0, m_held = 0, m_kill = 0;
    logic [31:0] m_hold = '0;
    rq_t         m_rq;
    fd_t         m_fd;

    function automatic fd_t bubble();
        fd_t b;
        b.ins = 32'h0000_0013; b.pc = '0; b.pc4 = '0; b.tgt = '0; b.way = '0; b.tk = 0; b.v = 0;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, ack, vld, stall, redir, input logic [63:0] rpc,
                              input logic [31:0] data, input bit btk, input logic [63:0] btgt,
                              input logic [1:0] bway);
        bit          dl = 0;
        logic [31:0] di = '0;
        if (!rst) begin
            m_pc = '0; m_busy = 0; m_held = 0; m_kill = 0; m_fd = bubble();
            return;
        end
        if (!m_busy && !m_held) begin
            if (ack) begin
                m_rq = '{m_pc, btgt, bway, btk};
                m_busy = 1;
                m_kill = redir;
            end
        end else if (m_busy) begin
            if (vld) begin
                m_busy = 0;
                if (m_kill) m_kill = 0;
                else if (!redir) begin
                    if (!stall) begin dl = 1; di = data; end
                    else begin m_held = 1; m_hold = data; end
                end
            end else if (redir) m_kill = 1;
        end else begin
            if (redir) m_held = 0;
            else if (!stall) begin m_held = 0; dl = 1; di = m_hold; end
        end
        if (dl) m_pc = m_rq.tk ? m_rq.tgt : m_rq.pc + 64'd4;
        if (redir) m_pc = rpc;
        if (redir || (!dl && !stall)) m_fd = bubble();
        else if (dl) m_fd = '{di, m_rq.pc, m_rq.pc + 64'd4, m_rq.tgt, m_rq.way, m_rq.tk, 1'b1};
    endtask

    // One clock: drive, check request outputs, advance model, check decode outputs.
    task automatic cyc(input bit rst, ack, vld, stall, redir, input logic [63:0] rpc,
                       input logic [31:0] data, input bit btk, input logic [63:0] btgt,
                       input logic [1:0] bway);
        bit exp_req;
        @(negedge clk);
        i_arst = rst; i_imem_ack = ack; i_imem_valid = vld; i_stall_dec = stall;
        i_redirect = redir; i_redirect_pc = rpc; i_imem_data = data;
        i_btb_hit_taken = btk; i_btb_target = btgt; i_btb_way = bway;
        #1;
        exp_req = rst && !m_busy && !m_held;
        chk("imem_req", 64'(o_imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", o_imem_addr, m_pc);
        @(posedge clk);
        model_step(rst, ack, vld, stall, redir, rpc, data, btk, btgt, bway);
        #1;
        chk("valid", 64'(o_valid), 64'(m_fd.v));
        chk("instruction", 64'(o_instruction), 64'(m_fd.ins));
        chk("pc", o_pc, m_fd.pc);
        chk("pc_plus4", o_pc_plus4, m_fd.pc4);
        chk("target_pred", o_pc_target_pred, m_fd.tgt);
        chk("btb_way", 64'(o_btb_way), 64'(m_fd.way));
        chk("pred_taken", 64'(o_branch_pred_taken), 64'(m_fd.tk));
    endtask

    initial begin
        int pend = 0;
        bit ack, vld;
        //         rst ack vld stl red rpc      data          tk tgt    way
        cyc(0, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(0, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        chk("lit_rst_req", 64'(o_imem_req), 64'd0);
        chk("lit_rst_instr", 64'(o_instruction), 64'h13);
        chk("lit_rst_addr", o_imem_addr, 64'h0);
        // Sequential fetch, 1-cycle memory
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h999, 2'd1);
        chk("lit_wait_req", 64'(o_imem_req), 64'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hAAAA_0001, 0, 64'h0,  2'd0);
        chk("lit_seq0_pc", o_pc, 64'h0);
        chk("lit_seq0_pc4", o_pc_plus4, 64'h4);
        chk("lit_seq0_valid", 64'(o_valid), 64'd1);
        chk("lit_seq0_addr", o_imem_addr, 64'h4);
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        chk("lit_gap_valid", 64'(o_valid), 64'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hAAAA_0002, 0, 64'h0,  2'd0);
        chk("lit_seq1_pc", o_pc, 64'h4);
        chk("lit_seq1_pc4", o_pc_plus4, 64'h8);
        chk("lit_seq1_addr", o_imem_addr, 64'h8);
        // BTB taken at 0x8 -> 0x40, way 2
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        1, 64'h40, 2'd2);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hAAAA_0003, 0, 64'h0,  2'd0);
        chk("lit_btb_pc", o_pc, 64'h8);
        chk("lit_btb_tgt", o_pc_target_pred, 64'h40);
        chk("lit_btb_way", 64'(o_btb_way), 64'd2);
        chk("lit_btb_taken", 64'(o_branch_pred_taken), 64'd1);
        chk("lit_btb_addr", o_imem_addr, 64'h40);
        // Stall while response arrives, held for 3 cycles
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 1, 1, 0, 64'h0,   32'hAAAA_0004, 0, 64'h0,  2'd0);
        cyc(1, 0, 0, 1, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 0, 1, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        chk("lit_hold_req", 64'(o_imem_req), 64'd0);
        chk("lit_hold_valid", 64'(o_valid), 64'd0);
        cyc(1, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        chk("lit_rel_pc", o_pc, 64'h40);
        chk("lit_rel_instr", 64'(o_instruction), 64'hAAAA_0004);
        chk("lit_rel_valid", 64'(o_valid), 64'd1);
        cyc(1, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        chk("lit_nodup_valid", 64'(o_valid), 64'd0);
        chk("lit_rel_addr", o_imem_addr, 64'h44);
        // Redirect to 0x100 in WAIT, stale response 2 cycles later
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 0, 0, 1, 64'h100, 32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hBAD0_0000, 0, 64'h0,  2'd0);
        chk("lit_kill_valid", 64'(o_valid), 64'd0);
        chk("lit_kill_addr", o_imem_addr, 64'h100);
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hAAAA_0005, 0, 64'h0,  2'd0);
        chk("lit_redir_pc", o_pc, 64'h100);
        chk("lit_redir_valid", 64'(o_valid), 64'd1);
        // Redirect with stall
        cyc(1, 0, 0, 1, 1, 64'h200, 32'h0,        0, 64'h0,  2'd0);
        chk("lit_rs_instr", 64'(o_instruction), 64'h13);
        chk("lit_rs_valid", 64'(o_valid), 64'd0);
        chk("lit_rs_addr", o_imem_addr, 64'h200);
        // Reset while WAIT, late response after release
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(0, 0, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hBAD0_0001, 0, 64'h0,  2'd0);
        chk("lit_late_valid", 64'(o_valid), 64'd0);
        chk("lit_late_addr", o_imem_addr, 64'h0);
        chk("lit_late_req", 64'(o_imem_req), 64'd1);
        // PC+4 wraps
        cyc(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 0, 64'h0, 2'd0);
        cyc(1, 1, 0, 0, 0, 64'h0,   32'h0,        0, 64'h0,  2'd0);
        cyc(1, 0, 1, 0, 0, 64'h0,   32'hAAAA_0006, 0, 64'h0,  2'd0);
        chk("lit_wrap_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("lit_wrap_pc4", o_pc_plus4, 64'h0);
        chk("lit_wrap_addr", o_imem_addr, 64'h0);

        // Randomized traffic; the responder keeps one pending response, even across reset
        for (int n = 0; n < 4000; n++) begin
            bit          rst, stall, redir, btk;
            logic [63:0] rpc, btgt;
            rst   = ($urandom % 150) != 0;
            stall = ($urandom % 3) == 0;
            redir = ($urandom % 15) == 0;
            btk   = ($urandom % 3) == 0;
            rpc   = {$urandom, $urandom & 32'hFFFF_FFFC};
            btgt  = {$urandom, $urandom & 32'hFFFF_FFFC};
            if (($urandom % 8) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8 | 64'(($urandom % 2) * 4);
            ack = 0; vld = 0;
            if (pend > 0) begin
                pend--;
                vld = (pend == 0);
            end else if (!m_busy && !m_held && ($urandom % 3) != 0) begin
                ack  = 1;
                pend = 1 + int'($urandom % 3);
            end
            cyc(rst, ack, vld, stall, redir, rpc, $urandom, btk, btgt, 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
